esp32_boot_sequencer: RTL and testbench

ESP32_BOOT_SEQUENCER -- requirements
Module: esp32_boot_sequencer

---
 rtl/esp32_boot_sequencer.sv | 133 +++++++++++++
 tb/tb_esp32_boot_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/esp32_boot_sequencer.sv
// ESP32 reset/bootloader strap sequencer.
// Drives active-low DTR/RTS-equivalent lines into the usual DTR/RTS-to-EN/IO0
// transistor decoder. A sequence pulls EN low, optionally holds IO0 low while
// EN rises (bootloader entry), and then releases both lines for a settle time.
// The lines never both go low, because the decoder treats 00 like 11.
// Optional feature macro: ESP32_SEQ_ABORT_EN adds an abort input that cuts a
// RESET or BOOT phase short and jumps straight to RELEASE.
module esp32_boot_sequencer #(
    parameter int unsigned C_reset_cycles  = 250000,
    parameter int unsigned C_boot_cycles   = 1250000,
    parameter int unsigned C_settle_cycles = 25000,
    parameter int unsigned C_cnt_bits      = 24
) (
    input  logic clk_25mhz,
    input  logic reset,
    input  logic start,
    input  logic mode,
`ifdef ESP32_SEQ_ABORT_EN
    input  logic abort,
`endif
    output logic ndtr,
    output logic nrts,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        StIdle,
        StReset,
        StBoot,
        StRelease
    } state_e;

    // Terminal counter values: each phase counts 0..C-1.
    localparam logic [C_cnt_bits-1:0] ResetLast  = C_cnt_bits'(C_reset_cycles - 1);
    localparam logic [C_cnt_bits-1:0] BootLast   = C_cnt_bits'(C_boot_cycles - 1);
    localparam logic [C_cnt_bits-1:0] SettleLast = C_cnt_bits'(C_settle_cycles - 1);

    state_e                state_q;
    logic [C_cnt_bits-1:0] cnt_q;
    logic                  mode_q;
    logic                  ndtr_q;
    logic                  nrts_q;
    logic                  busy_q;
    logic                  done_q;

    // Sequencer FSM: state, phase counter and registered line outputs together.
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            ndtr_q  <= 1'b1;
            nrts_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        // EN low, IO0 high
                        state_q <= StReset;
                        cnt_q   <= '0;
                        mode_q  <= mode;
                        ndtr_q  <= 1'b1;
                        nrts_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                StReset: begin
                    if (cnt_q == ResetLast) begin
                        cnt_q <= '0;
                        if (mode_q) begin
                            // Both bits flip together so 00 is never presented.
                            state_q <= StBoot;
                            ndtr_q  <= 1'b0;
                            nrts_q  <= 1'b1;
                        end else begin
                            state_q <= StRelease;
                            ndtr_q  <= 1'b1;
                            nrts_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StBoot: begin
                    if (cnt_q == BootLast) begin
                        state_q <= StRelease;
                        cnt_q   <= '0;
                        ndtr_q  <= 1'b1;
                        nrts_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRelease: begin
                    if (cnt_q == SettleLast) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    ndtr_q  <= 1'b1;
                    nrts_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
`ifdef ESP32_SEQ_ABORT_EN
            // Abort overrides the phase logic above; settle and done still follow.
            if (abort && (state_q == StReset || state_q == StBoot)) begin
                state_q <= StRelease;
                cnt_q   <= '0;
                ndtr_q  <= 1'b1;
                nrts_q  <= 1'b1;
            end
`endif
        end
    end

    assign ndtr = ndtr_q;
    assign nrts = nrts_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_esp32_boot_sequencer.sv
// Self-checking bench for esp32_boot_sequencer with short phase lengths.
// Expected outputs come from a timeline model: the position k within the
// current sequence and the offset at which RELEASE begins.
module tb_esp32_boot_sequencer;

    localparam int R = 4;
    localparam int B = 6;
    localparam int S = 3;

    logic clk = 1'b0;
    logic reset, start, mode, abort;
    logic ndtr, nrts, busy, done;

    int n_cmp = 0;
    int n_fail = 0;

    // Model: active sequence, 1-based cycle position k, offset where release starts.
    bit m_active = 1'b0;
    bit m_done = 1'b0;
    int m_k = 0;
    int m_rel_at = 0;

    always #5 clk = ~clk;

    esp32_boot_sequencer #(
        .C_reset_cycles (R),
        .C_boot_cycles  (B),
        .C_settle_cycles(S),
        .C_cnt_bits     (8)
    ) dut (
        .clk_25mhz(clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
`ifdef ESP32_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .ndtr     (ndtr),
        .nrts     (nrts),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag);
        logic [1:0] exp_lines;
        logic exp_busy;
        if (!m_active) begin
            exp_lines = 2'b11;
            exp_busy  = 1'b0;
        end else begin
            exp_busy = 1'b1;
            if (m_k <= R) exp_lines = 2'b10;
            else if (m_k < m_rel_at) exp_lines = 2'b01;
            else exp_lines = 2'b11;
        end
        n_cmp++;
        assert ({ndtr, nrts} === exp_lines) else begin
            n_fail++;
            $error("FAIL %s lines: got %b want %b", tag, {ndtr, nrts}, exp_lines);
        end
        n_cmp++;
        assert (busy === exp_busy) else begin
            n_fail++;
            $error("FAIL %s busy: got %b want %b", tag, busy, exp_busy);
        end
        n_cmp++;
        assert (done === (m_active ? 1'b0 : m_done)) else begin
            n_fail++;
            $error("FAIL %s done: got %b want %b", tag, done, m_done);
        end
        n_cmp++;
        assert ({ndtr, nrts} !== 2'b00) else begin
            n_fail++;
            $error("FAIL %s never00: got %b want not 00", tag, {ndtr, nrts});
        end
    endtask

    task automatic model_update(input logic rst, input logic st, input logic md,
                                input logic ab);
        logic ab_eff;
`ifdef ESP32_SEQ_ABORT_EN
        ab_eff = ab;
`else
        ab_eff = 1'b0;
`endif
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end else if (!m_active) begin
            m_done = 1'b0;
            if (st) begin
                m_active = 1'b1;
                m_k      = 1;
                m_rel_at = md ? (R + B + 1) : (R + 1);
            end
        end else begin
            if (ab_eff && m_k < m_rel_at) m_rel_at = m_k + 1;
            m_k++;
            if (m_k == m_rel_at + S) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
    endtask

    task automatic step(input logic rst, input logic st, input logic md, input logic ab,
                        input bit chk, input string tag);
        reset = rst;
        start = st;
        mode  = md;
        abort = ab;
        if (chk) check(tag);
        model_update(rst, st, md, ab);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        abort = 1'b0;
        #1;
        // Reset with start held high: no effect.
        step(1, 1, 1, 0, 0, "rst0");
        step(1, 1, 1, 0, 1, "rst1");
        step(0, 0, 0, 0, 1, "idle");
        step(0, 0, 0, 0, 1, "idle");

        // Bootloader run with extra start pulses; restart in the done cycle.
        step(0, 1, 1, 0, 1, "boot_c0");
        for (int c = 1; c <= 14; c++)
            step(0, (c == 3 || c == 9 || c == 14), 1'b0, 0, 1, "boot_run");
        for (int c = 0; c < 16; c++) step(0, 0, 0, 0, 1, "boot_rerun");

        // Plain run with mode toggling mid-sequence.
        step(0, 1, 0, 0, 1, "run_c0");
        for (int c = 1; c <= 10; c++) step(0, 0, c[0], 0, 1, "run_modetog");

        // Reset in cycle 7 of a bootloader run.
        step(0, 1, 1, 0, 1, "rstmid_c0");
        for (int c = 1; c <= 16; c++) step((c == 7), 0, 0, 0, 1, "rstmid");

`ifdef ESP32_SEQ_ABORT_EN
        // Abort in cycle 6 of a bootloader run; abort with start in idle.
        step(0, 1, 1, 0, 1, "abort_c0");
        for (int c = 1; c <= 12; c++) step(0, 0, 0, (c == 6), 1, "abort_run");
        step(0, 1, 1, 1, 1, "abort_idle");
        for (int c = 1; c <= 16; c++) step(0, 0, 0, 0, 1, "abort_idle_run");
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0),
                 1'($urandom), ($urandom_range(0, 11) == 0), 1, "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
